// File: rtl/sb_tx_scheduler.sv
// Sideband TX scheduler: owns the serializer input, sends the bring-up clock pattern, then
// round-robins header(+data) messages from N_REQ sources. Optional macro: SB_TX_PARITY_GEN_EN.
module sb_tx_scheduler #(
    parameter int N_REQ       = 3,
    parameter int PATTERN_MIN = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start_pattern,
    input  logic                i_rx_pattern_done,
    input  logic                i_flush,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [N_REQ-1:0]    i_req_has_data,
    input  logic [64*N_REQ-1:0] i_req_header,
    input  logic [64*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]    o_grant,
    output logic                o_ser_valid,
    output logic [63:0]         o_ser_data,
    input  logic                i_ser_ready,
    output logic                o_pattern_done,
    output logic                o_busy
);

    localparam int          PW           = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [63:0] PATTERN_WORD = {32{2'b10}};

    typedef enum logic [2:0] {
        ST_IDLE, ST_PATTERN, ST_ARB, ST_HDR, ST_DATA, ST_GAP
    } state_t;

    localparam state_t AFTER_MSG = (GAP_CYCLES == 0) ? ST_ARB : ST_GAP;

    state_t        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]    pat_cnt_q, pat_cnt_d;
    logic [3:0]    gap_cnt_q, gap_cnt_d;
    logic          rx_done_q, rx_done_d;
    logic          pattern_done_q, pattern_done_d;
    logic [63:0]   hdr_q, hdr_d;
    logic [63:0]   data_q, data_d;
    logic          has_data_q, has_data_d;

    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [63:0]   cap_hdr;
    logic [63:0]   cap_data;
    logic          cap_has_data;
    logic          accept;
    logic          pat_exit;
    int            idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            pat_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            rx_done_q      <= 1'b0;
            pattern_done_q <= 1'b0;
            hdr_q          <= '0;
            data_q         <= '0;
            has_data_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            pat_cnt_q      <= pat_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            rx_done_q      <= rx_done_d;
            pattern_done_q <= pattern_done_d;
            hdr_q          <= hdr_d;
            data_q         <= data_d;
            has_data_q     <= has_data_d;
        end
    end

    // Round-robin search: first active requester at or after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && i_req[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        cap_hdr      = i_req_header[64*int'(win_idx) +: 64];
        cap_data     = i_req_data[64*int'(win_idx) +: 64];
        cap_has_data = i_req_has_data[win_idx];
`ifdef SB_TX_PARITY_GEN_EN
        cap_hdr[62]  = ^cap_hdr[61:0];
        cap_hdr[63]  = cap_has_data ? ^cap_data : 1'b0;
`endif
    end

    assign accept   = o_ser_valid && i_ser_ready;
    assign pat_exit = (state_q == ST_PATTERN) && accept &&
                      (({1'b0, pat_cnt_q} + 9'd1) >= 9'(PATTERN_MIN)) &&
                      (rx_done_q || i_rx_pattern_done);

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        pat_cnt_d      = pat_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        rx_done_d      = rx_done_q || i_rx_pattern_done;
        pattern_done_d = pattern_done_q;
        hdr_d          = hdr_q;
        data_d         = data_q;
        has_data_d     = has_data_q;
        if (i_flush) begin
            state_d        = ST_IDLE;
            rx_done_d      = 1'b0;
            pattern_done_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pat_cnt_d      = '0;
                    pattern_done_d = 1'b0;
                    if (i_start_pattern) state_d = ST_PATTERN;
                end
                ST_PATTERN: begin
                    if (accept && (pat_cnt_q != 8'hFF)) pat_cnt_d = pat_cnt_q + 8'd1;
                    if (pat_exit) begin
                        state_d        = ST_ARB;
                        pattern_done_d = 1'b1;
                    end
                end
                ST_ARB: begin
                    if (win_found) begin
                        hdr_d      = cap_hdr;
                        data_d     = cap_data;
                        has_data_d = cap_has_data;
                        rr_ptr_d   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
                        state_d    = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        state_d   = has_data_q ? ST_DATA : AFTER_MSG;
                        gap_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        state_d   = AFTER_MSG;
                        gap_cnt_d = '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 4'(GAP_CYCLES - 1)) state_d = ST_ARB;
                    else gap_cnt_d = gap_cnt_q + 4'd1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_ser_valid    = 1'b0;
        o_ser_data     = '0;
        o_grant        = '0;
        o_busy         = (state_q != ST_IDLE) && (state_q != ST_ARB);
        o_pattern_done = pattern_done_q;
        case (state_q)
            ST_PATTERN: begin
                o_ser_valid = 1'b1;
                o_ser_data  = PATTERN_WORD;
            end
            ST_HDR: begin
                o_ser_valid = 1'b1;
                o_ser_data  = hdr_q;
            end
            ST_DATA: begin
                o_ser_valid = 1'b1;
                o_ser_data  = data_q;
            end
            ST_ARB: begin
                if (win_found && !i_flush) o_grant[win_idx] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
